// File: rtl/snitch_cluster_boot_ctrl.sv
// Boot sequencer for the cluster narrow AXI slave port: writes the entry point to SCRATCH_1,
// then all-ones to CL_CLINT_SET to wake every core.
module snitch_cluster_boot_ctrl #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 64,
  parameter int unsigned          NrCores       = 9,
  parameter logic [AddrWidth-1:0] ScratchAddr   = '0,
  parameter logic [AddrWidth-1:0] ClintSetAddr  = '0,
  parameter int unsigned          TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            entry_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic [2:0]             aw_size_o,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic [1:0]             b_resp_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   err_step_o
);

  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StAw0  = 4'd1;
  localparam logic [3:0] StW0   = 4'd2;
  localparam logic [3:0] StB0   = 4'd3;
  localparam logic [3:0] StAw1  = 4'd4;
  localparam logic [3:0] StW1   = 4'd5;
  localparam logic [3:0] StB1   = 4'd6;
  localparam logic [3:0] StDone = 4'd7;
  localparam logic [3:0] StErr  = 4'd8;

  localparam logic [1:0]           RespOkay = 2'b00;
  localparam logic [NrCores-1:0]   CoreMask = '1;
  localparam int unsigned          CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0]  CntLast  = CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  logic [3:0]          state_q, state_d;
  logic [31:0]         entry_q;
  logic [CntWidth-1:0] cnt_q;
  logic                error_q, err_step_q;
  logic                in_aw, in_w, in_b, in_xfer, step;
  logic                start_ok, wd_fire, bad_resp;

  assign in_aw    = (state_q == StAw0) || (state_q == StAw1);
  assign in_w     = (state_q == StW0)  || (state_q == StW1);
  assign in_b     = (state_q == StB0)  || (state_q == StB1);
  assign in_xfer  = in_aw || in_w || in_b;
  assign step     = (state_q == StAw1) || (state_q == StW1) || (state_q == StB1);
  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign bad_resp = in_b && b_valid_i && (b_resp_i != RespOkay);
  // The watchdog only flags; valids stay asserted so the bus never sees a withdrawn request.
  assign wd_fire  = (TimeoutCycles != 0) && in_xfer && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (start_i) state_d = StAw0;
      StAw0: if (aw_ready_i) state_d = StW0;
      StW0:  if (w_ready_i)  state_d = StB0;
      StB0:  if (b_valid_i)  state_d = (b_resp_i == RespOkay) ? StAw1 : StErr;
      StAw1: if (aw_ready_i) state_d = StW1;
      StW1:  if (w_ready_i)  state_d = StB1;
      StB1:  if (b_valid_i)  state_d = (b_resp_i == RespOkay) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      err_step_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) entry_q <= entry_i;
      // Saturating so a long stall cannot wrap around and re-fire.
      if ((state_d != state_q) || !in_xfer) cnt_q <= '0;
      else if (cnt_q != CntLast)            cnt_q <= cnt_q + 1'b1;
      if (start_ok) begin
        error_q    <= 1'b0;
        err_step_q <= 1'b0;
      end else if (!error_q && (wd_fire || bad_resp)) begin
        error_q    <= 1'b1;
        err_step_q <= step;
      end
    end
  end

  assign aw_size_o  = 3'($clog2(DataWidth/8));
  assign aw_valid_o = in_aw;
  assign aw_addr_o  = in_aw ? (step ? ClintSetAddr : ScratchAddr) : '0;
  assign w_valid_o  = in_w;
  assign w_data_o   = in_w ? (step ? DataWidth'(CoreMask) : DataWidth'(entry_q)) : '0;
  assign w_strb_o   = {(DataWidth/8){in_w}};
  assign w_last_o   = in_w;
  assign b_ready_o  = in_b;
  assign busy_o     = in_xfer;
  assign done_o     = (state_q == StDone);
  assign error_o    = error_q || wd_fire;
  assign err_step_o = error_q ? err_step_q : (wd_fire && step);

endmodule
